// File: rtl/onn_run_sequencer.sv
// onn_run_sequencer
// Run controller for neuron_bank_3x5. Loads an initial phase pattern into the
// bank, then alternates free-running oscillation windows (RUN) with a
// state-check strobe (CHECK) and an evaluation cycle (EVAL). It counts the
// neurons that changed at each check and finishes either when STABLE_CNT
// consecutive checks saw no change (converged) or after MAX_ITER iterations.
//
// Ports:
//   sclk, rst_n        clock (rising edge) and asynchronous active-low reset
//   start, abort       host control; start only honoured in IDLE, abort always
//   ini_state [4N]     initial phases, neuron i at [4i +: 4]
//   state_changed [N]  per-neuron change flags from the bank, valid in EVAL
//   phi_out [4N]       current bank phases, captured into result at run end
//   re, re_n, drop, state_cheak, state [4N]   bank controls
//   busy, done         status; done is a one-cycle pulse at run end
//   converged, iter_cnt, last_changed, result   run outcome
module onn_run_sequencer #(
  parameter int N          = 210,
  parameter int SETTLE_CYC = 64,
  parameter int MAX_ITER   = 32,
  parameter int STABLE_CNT = 3,
  localparam int IW = $clog2(MAX_ITER + 1),
  localparam int LW = $clog2(N + 1)
) (
  input  logic            sclk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [4*N-1:0]  ini_state,
  input  logic [N-1:0]    state_changed,
  input  logic [4*N-1:0]  phi_out,
  output logic            re,
  output logic            re_n,
  output logic            drop,
  output logic            state_cheak,
  output logic [4*N-1:0]  state,
  output logic            busy,
  output logic            done,
  output logic            converged,
  output logic [IW-1:0]   iter_cnt,
  output logic [LW-1:0]   last_changed,
  output logic [4*N-1:0]  result
);

  // One counter serves both the 2-cycle LOAD and the SETTLE_CYC-cycle RUN.
  localparam int CW = $clog2(SETTLE_CYC + 2);
  localparam int SW = $clog2(STABLE_CNT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, CHECK, EVAL, DONE} fsm_t;

  fsm_t          cur_st;
  fsm_t          nxt_st;
  logic [CW-1:0] cyc_cnt;
  logic [SW-1:0] stable;
  logic [LW-1:0] pop;
  logic [SW-1:0] stable_nxt;
  logic [IW-1:0] iter_nxt;

  // Popcount of the change flags; only consumed on the EVAL exit edge.
  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + LW'(state_changed[i]);
    end
  end

  // Streak and iteration values as they will be after this EVAL.
  assign stable_nxt = (pop == '0) ? stable + SW'(1) : '0;
  assign iter_nxt   = iter_cnt + IW'(1);

  // State register.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      cur_st <= IDLE;
    end else begin
      cur_st <= nxt_st;
    end
  end

  // Next-state logic. Abort overrides everything, including a start in IDLE.
  always_comb begin
    nxt_st = cur_st;
    if (abort) begin
      nxt_st = IDLE;
    end else begin
      case (cur_st)
        IDLE:    if (start) nxt_st = LOAD;
        LOAD:    if (cyc_cnt == CW'(1)) nxt_st = RUN;
        RUN:     if (cyc_cnt == CW'(SETTLE_CYC - 1)) nxt_st = CHECK;
        CHECK:   nxt_st = EVAL;
        EVAL: begin
          if (stable_nxt == SW'(STABLE_CNT) || iter_nxt == IW'(MAX_ITER)) begin
            nxt_st = DONE;
          end else begin
            nxt_st = RUN;
          end
        end
        DONE:    nxt_st = IDLE;
        default: nxt_st = IDLE;
      endcase
    end
  end

  // Bank controls and status decoded purely from the registered state.
  always_comb begin
    re          = (cur_st == RUN);
    re_n        = (cur_st == LOAD);
    drop        = (cur_st == CHECK) || (cur_st == EVAL);
    state_cheak = (cur_st == CHECK);
    busy        = (cur_st != IDLE);
    done        = (cur_st == DONE);
  end

  // Datapath: phase pattern, counters and run outcome. An abort freezes all
  // of these so the previous outcome stays visible to the host.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= '0;
      result       <= '0;
      iter_cnt     <= '0;
      last_changed <= '0;
      converged    <= 1'b0;
      stable       <= '0;
      cyc_cnt      <= '0;
    end else if (!abort) begin
      case (cur_st)
        IDLE: begin
          if (start) begin
            state        <= ini_state;
            iter_cnt     <= '0;
            last_changed <= '0;
            converged    <= 1'b0;
            stable       <= '0;
            cyc_cnt      <= '0;
          end
        end
        LOAD: begin
          cyc_cnt <= (cyc_cnt == CW'(1)) ? '0 : cyc_cnt + CW'(1);
        end
        RUN: begin
          cyc_cnt <= (cyc_cnt == CW'(SETTLE_CYC - 1)) ? '0 : cyc_cnt + CW'(1);
        end
        EVAL: begin
          last_changed <= pop;
          iter_cnt     <= iter_nxt;
          stable       <= stable_nxt;
          // Convergence wins when the streak completes on the last iteration.
          converged    <= (stable_nxt == SW'(STABLE_CNT));
        end
        DONE: begin
          result <= phi_out;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onn_run_sequencer.sv
// tb_onn_run_sequencer
// Self-checking bench for onn_run_sequencer. A behavioural model tracks each
// run as an offset from the accepted start edge and derives the phase from
// that offset arithmetically; a compare process checks every output against
// it on each falling clock edge. Directed scenarios add literal timing and
// outcome expectations, followed by randomized runs with random aborts.
module tb_onn_run_sequencer;

  localparam int N          = 20;
  localparam int SETTLE_CYC = 4;
  localparam int MAX_ITER   = 6;
  localparam int STABLE_CNT = 3;
  localparam int IW         = $clog2(MAX_ITER + 1);
  localparam int LW         = $clog2(N + 1);

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_RUN   = 2;
  localparam int P_CHECK = 3;
  localparam int P_EVAL  = 4;
  localparam int P_DONE  = 5;

  logic           sclk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [4*N-1:0] ini_state = '0;
  logic [N-1:0]   state_changed = '0;
  logic [4*N-1:0] phi_out = '0;
  logic           re, re_n, drop, state_cheak, busy, done, converged;
  logic [4*N-1:0] state, result;
  logic [IW-1:0]  iter_cnt;
  logic [LW-1:0]  last_changed;

  onn_run_sequencer #(
    .N(N), .SETTLE_CYC(SETTLE_CYC), .MAX_ITER(MAX_ITER), .STABLE_CNT(STABLE_CNT)
  ) dut (
    .sclk(sclk), .rst_n(rst_n), .start(start), .abort(abort),
    .ini_state(ini_state), .state_changed(state_changed), .phi_out(phi_out),
    .re(re), .re_n(re_n), .drop(drop), .state_cheak(state_cheak),
    .state(state), .busy(busy), .done(done), .converged(converged),
    .iter_cnt(iter_cnt), .last_changed(last_changed), .result(result)
  );

  always #5 sclk = ~sclk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int k        = 0;
  int sc_mode  = 0;
  int phi_mode = 0;
  int pops[6]  = '{0, 0, 7, 0, 0, 0};
  int cheak_q[$];
  int ren_q[$];
  int done_q[$];
  logic [4*N-1:0] pat;

  always @(posedge sclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Behavioural model: a run is described by its offset from the start edge.
  bit             m_active = 1'b0;
  int             m_off = 0;
  int             m_done_off = 0;
  int             m_iter = 0;
  int             m_stab = 0;
  int             m_last = 0;
  bit             m_conv = 1'b0;
  logic [4*N-1:0] m_state = '0;
  logic [4*N-1:0] m_result = '0;

  function automatic int m_phase();
    int p;
    if (!m_active) return P_IDLE;
    if (m_off <= 2) return P_LOAD;
    if (m_done_off != 0 && m_off == m_done_off) return P_DONE;
    p = (m_off - 3) % (SETTLE_CYC + 2);
    if (p < SETTLE_CYC) return P_RUN;
    if (p == SETTLE_CYC) return P_CHECK;
    return P_EVAL;
  endfunction

  always @(posedge sclk or negedge rst_n) begin
    int cur;
    int pc;
    if (!rst_n) begin
      m_active = 1'b0; m_off = 0; m_done_off = 0; m_iter = 0; m_stab = 0;
      m_last = 0; m_conv = 1'b0; m_state = '0; m_result = '0;
    end else begin
      cur = m_phase();
      if (abort) begin
        m_active = 1'b0;
      end else begin
        if (cur == P_EVAL) begin
          pc = $countones(state_changed);
          m_last = pc;
          m_iter = m_iter + 1;
          m_stab = (pc == 0) ? m_stab + 1 : 0;
          if (m_stab == STABLE_CNT) begin
            m_conv = 1'b1;
            m_done_off = m_off + 1;
          end else if (m_iter == MAX_ITER) begin
            m_conv = 1'b0;
            m_done_off = m_off + 1;
          end
        end
        if (cur == P_DONE) begin
          m_result = phi_out;
          m_active = 1'b0;
        end
        if (cur == P_IDLE && start) begin
          m_active = 1'b1; m_off = 0; m_done_off = 0; m_state = ini_state;
          m_iter = 0; m_stab = 0; m_last = 0; m_conv = 1'b0;
        end
        if (m_active) m_off = m_off + 1;
      end
    end
  end

  // Bank-side driver: change flags matter only in EVAL, otherwise noise.
  always @(posedge sclk) begin
    logic [95:0] r;
    logic [N-1:0] v;
    #2;
    r = {$urandom, $urandom, $urandom};
    v = N'($urandom);
    if (m_phase() == P_EVAL) begin
      case (sc_mode)
        0:       v = '0;
        1:       v = N'(1) << 5;
        2:       v = (pops[m_iter] == 0) ? '0 : (N'(7'h7F) << $urandom_range(0, N - 7));
        default: if ($urandom_range(0, 1) == 0) v = '0;
      endcase
    end
    state_changed = v;
    phi_out = (phi_mode != 0) ? pat : r[4*N-1:0];
  end

  // Per-cycle comparison against the model.
  always @(negedge sclk) begin
    int ph;
    ph = m_phase();
    check("busy", 128'(busy), 128'(ph != P_IDLE));
    check("re", 128'(re), 128'(ph == P_RUN));
    check("re_n", 128'(re_n), 128'(ph == P_LOAD));
    check("drop", 128'(drop), 128'(ph == P_CHECK || ph == P_EVAL));
    check("state_cheak", 128'(state_cheak), 128'(ph == P_CHECK));
    check("done", 128'(done), 128'(ph == P_DONE));
    check("state", 128'(state), 128'(m_state));
    check("result", 128'(result), 128'(m_result));
    check("iter_cnt", 128'(iter_cnt), 128'(m_iter));
    check("last_changed", 128'(last_changed), 128'(m_last));
    check("converged", 128'(converged), 128'(m_conv));
    if (state_cheak) cheak_q.push_back(cyc);
    if (re_n) ren_q.push_back(cyc);
    if (done) done_q.push_back(cyc);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sclk);
      #2;
    end
  endtask

  // Caller sits just after an edge; start is sampled at the next edge (k).
  task automatic applyStimulus(input bit rand_ini);
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    if (rand_ini) ini_state = r[4*N-1:0];
    cheak_q.delete(); ren_q.delete(); done_q.delete();
    start = 1'b1;
    k = cyc + 1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic waitIdle();
    int i;
    for (i = 0; i < 500 && m_active; i++) tick(1);
    if (m_active) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL run_timeout: still busy after %0d cycles, expected idle", i);
    end
  endtask

  task automatic checkOutput(input string tag, input int done_rel, input bit conv,
                             input int iters, input int lastc);
    check({tag, "_done_count"}, 128'(done_q.size()), 128'(1));
    if (done_q.size() > 0) check({tag, "_done_cyc"}, 128'(done_q[0]), 128'(k + done_rel));
    check({tag, "_converged"}, 128'(converged), 128'(conv));
    check({tag, "_iter_cnt"}, 128'(iter_cnt), 128'(iters));
    check({tag, "_last_changed"}, 128'(last_changed), 128'(lastc));
    check({tag, "_busy_after"}, 128'(busy), 128'(0));
  endtask

  initial begin
    logic [95:0] r;
    for (int i = 0; i < N; i++) pat[4*i +: 4] = 4'(i % 16);

    // Reset, then a long idle stretch with changing inputs.
    tick(5);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_state", 128'(state), 128'(0));
    check("rst_result", 128'(result), 128'(0));
    check("rst_ctrl", 128'({re, re_n, drop, state_cheak, done, converged}), 128'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      r = {$urandom, $urandom, $urandom};
      ini_state = r[4*N-1:0];
      tick(1);
    end
    check("idle_busy", 128'(busy), 128'(0));
    check("idle_state", 128'(state), 128'(0));

    // Immediate convergence: checks at k+7, k+13, k+19 (spec numbering).
    sc_mode = 0;
    applyStimulus(1'b1);
    waitIdle();
    checkOutput("conv", 20, 1'b1, 3, 0);
    check("conv_cheak_count", 128'(cheak_q.size()), 128'(3));
    if (cheak_q.size() == 3) begin
      check("conv_cheak0", 128'(cheak_q[0]), 128'(k + 6));
      check("conv_cheak1", 128'(cheak_q[1]), 128'(k + 12));
      check("conv_cheak2", 128'(cheak_q[2]), 128'(k + 18));
    end
    check("conv_ren_count", 128'(ren_q.size()), 128'(2));
    if (ren_q.size() > 0) check("conv_ren_first", 128'(ren_q[0]), 128'(k));

    // Non-convergence, restarted in the first idle cycle after done.
    sc_mode = 1;
    applyStimulus(1'b1);
    waitIdle();
    checkOutput("noconv", 38, 1'b0, 6, 1);

    // Streak broken by a popcount of 7; converges exactly on the last iteration.
    sc_mode = 2;
    applyStimulus(1'b1);
    waitIdle();
    checkOutput("streak", 38, 1'b1, 6, 0);

    // Result capture, with a start pulse mid-run that must be ignored.
    sc_mode = 0;
    phi_mode = 1;
    applyStimulus(1'b1);
    tick(4);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    waitIdle();
    checkOutput("capture", 20, 1'b1, 3, 0);
    check("capture_result", 128'(result), 128'(pat));
    phi_mode = 0;

    // Abort in RUN of iteration 2: no done, previous result kept.
    sc_mode = 1;
    tick(2);
    applyStimulus(1'b1);
    while (cyc < k + 9) tick(1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_no_done", 128'(done_q.size()), 128'(0));
    check("abort_result", 128'(result), 128'(pat));
    check("abort_iter", 128'(iter_cnt), 128'(1));
    tick(3);

    // Start and abort together in IDLE: stays idle.
    start = 1'b1;
    abort = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle", 128'(busy), 128'(0));

    // Reset asserted during CHECK drops the strobe immediately.
    applyStimulus(1'b1);
    while (cyc < k + 6) tick(1);
    check("pre_rst_cheak", 128'(state_cheak), 128'(1));
    rst_n = 1'b0;
    #1;
    check("rst_cheak_async", 128'(state_cheak), 128'(0));
    check("rst_busy_async", 128'(busy), 128'(0));
    check("rst_result_async", 128'(result), 128'(0));
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Randomized runs with random aborts and ignored mid-run starts.
    sc_mode = 3;
    for (int run = 0; run < 12; run++) begin
      applyStimulus(1'b1);
      if ($urandom_range(0, 2) == 0) begin
        tick($urandom_range(0, 40));
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
      end else if ($urandom_range(0, 1) == 0) begin
        tick($urandom_range(0, 10));
        if (m_active) begin
          start = 1'b1;
          tick(1);
          start = 1'b0;
        end
      end
      waitIdle();
      tick($urandom_range(0, 2));
    end
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
